ibram_bank_writer: RTL
======================

Name: ibram_bank_writer

Overview:
- Sits directly downstream of the input write controller; consumes its write stream (data, enable, write-enable, bank index, done) and drives it the per-bank `full` flags.
- Owns NUM_BANKS input-activation BRAM banks. Each bank is split into two ping-pong halves of BANK_DEPTH words.
- Routes each write to the selected bank's current write half, seals halves for the array-side reader, and tracks half ownership between writer and reader.

Parameters:
- STREAM_WIDTH, 128, width of one write word.
- NUM_BANKS, 16, number of IBRAM banks.
- BANK_DEPTH, 64, words per ping-pong half; total bank depth is 2*BANK_DEPTH.
- BANK_W, $clog2(NUM_BANKS), width of the bank index.
- ADDR_W, $clog2(2*BANK_DEPTH), BRAM port-A address width; address = {half, offset}.
- LEN_W, $clog2(BANK_DEPTH)+1, width of the sealed-half length.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- wr_data, in, STREAM_WIDTH, write word from the input write controller.
- wr_en, in, 1, write request strobe.
- wr_we, in, 1, write qualifier; a write occurs only when wr_en & wr_we.
- wr_bank, in, BANK_W, target bank.
- wr_done, in, 1, one-cycle pulse: end of layer, seal all partial halves.
- full, out, NUM_BANKS, bank b cannot accept writes.
- bram_ena, out, NUM_BANKS, port-A enable per bank.
- bram_we, out, NUM_BANKS, port-A write enable per bank.
- bram_addr, out, NUM_BANKS*ADDR_W, port-A address per bank.
- bram_din, out, NUM_BANKS*STREAM_WIDTH, port-A data per bank.
- rd_avail, out, NUM_BANKS, bank b has a sealed half owned by the reader.
- rd_half, out, NUM_BANKS, which half the reader should read.
- rd_len, out, NUM_BANKS*LEN_W, valid word count of that half.
- rd_release, in, NUM_BANKS, one-cycle pulse: reader finished with rd_half[b].

Behaviour:
- Per-bank state:
  - wr_half (1b), wr_ptr (LEN_W), rd_half (1b).
  - busy[2], set means the half is owned by the reader.
  - len[2] (LEN_W each).
- Reset:
  - All state and all outputs are 0.
  - full=0, rd_avail=0, rd_len=0, bram_* = 0.
- full[b] = busy[b][wr_half[b]]. It is combinational from registered state, so it changes the cycle after the state update.
- Accepted write: wr_en & wr_we & !full[wr_bank].
  - Next cycle: bram_ena/bram_we[wr_bank]=1, bram_addr = {wr_half, wr_ptr}, bram_din = wr_data.
  - All other banks: ena/we=0.
  - Write latency is 1 cycle.
- Write to a full bank:
  - The write is dropped: no BRAM strobe, wr_ptr unchanged.
  - Upstream must hold the word until full deasserts.
- wr_en & !wr_we: no action.
- Seal on fill: an accepted write with wr_ptr == BANK_DEPTH-1 seals the half in the same update.
  - busy[wr_half] <= 1, len[wr_half] <= BANK_DEPTH.
  - wr_half toggles, wr_ptr <= 0.
- Seal on wr_done: every bank with wr_ptr > 0 seals with len = wr_ptr.
  - Banks with wr_ptr == 0 are untouched; an empty half is never sealed.
  - If an accepted write coincides with wr_done on the same bank, the write is counted first, so len = wr_ptr+1.
  - If that write also fills the half, only one seal occurs.
- rd_avail[b] = busy[b][rd_half[b]]; rd_len[b] = len[b][rd_half[b]].
- rd_release[b] while rd_avail[b]: busy[b][rd_half] <= 0 and rd_half toggles. rd_release with rd_avail=0 is ignored.
- Reader consumes halves strictly in seal order. After reset rd_half == wr_half, so ordering holds.
- Release and seal on the same bank in the same cycle:
  - Both take effect; they always target opposite halves.
  - full updates from the post-update state.
- Both halves busy: full=1 until a release.
- Reset mid-operation: all halves are freed and pointers cleared. BRAM contents are not cleared.

Optional Feature:
- Macro IBRAM_WR_ERR_EN.
- When defined, adds two outputs:
  - wr_err (1b, sticky): set on any write attempt to a full bank or with wr_bank >= NUM_BANKS; cleared only by reset.
  - drop_cnt (16b): counts dropped writes and saturates at 0xFFFF.
- When undefined:
  - Neither port exists.
  - Out-of-range wr_bank writes are silently dropped.
  - The logic is otherwise identical.

Test Plan:
- NUM_BANKS=4, BANK_DEPTH=4; 4 writes to bank 2 (data 0x1..0x4).
  - bram_addr[2] = 0,1,2,3.
  - rd_avail[2]=1, rd_half[2]=0, rd_len[2]=4, full[2]=0.
- Continue 4 more writes to bank 2, no release.
  - Addresses 4..7 are written.
  - full[2]=1; a 9th write produces no bram_we.
  - rd_release[2] pulse → full[2]=0 next cycle, rd_half[2]=1.
- 3 writes to bank 0, 1 write to bank 1, then wr_done.
  - rd_len[0]=3, rd_len[1]=1, rd_avail[3]=0.
- A write to bank 1 at wr_ptr=2 in the same cycle as wr_done → rd_len[1]=3.
  - The next write to bank 1 uses address 4.
- Bank 0 with both halves busy: rd_release[0] plus an attempted write in the same cycle.
  - That write is dropped; the next-cycle write is accepted into the freed half.
- Assert rst_n=0 mid-fill on bank 3 (wr_ptr=2).
  - All outputs 0.
  - The first post-reset write to bank 3 targets address 0.

Source files
------------

// File: rtl/ibram_bank_writer.sv
// Ping-pong IBRAM bank writer: routes the write stream into per-bank halves, seals them for the reader.
// Optional IBRAM_WR_ERR_EN adds a sticky wr_err flag and a saturating drop_cnt.
module ibram_bank_writer #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int BANK_DEPTH   = 64,
  parameter int BANK_W       = $clog2(NUM_BANKS),
  parameter int ADDR_W       = $clog2(2*BANK_DEPTH),
  parameter int LEN_W        = $clog2(BANK_DEPTH)+1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [STREAM_WIDTH-1:0]        wr_data,
  input  logic                           wr_en,
  input  logic                           wr_we,
  input  logic [BANK_W-1:0]              wr_bank,
  input  logic                           wr_done,
  output logic [NUM_BANKS-1:0]           full,
  output logic [NUM_BANKS-1:0]           bram_ena,
  output logic [NUM_BANKS-1:0]           bram_we,
  output logic [NUM_BANKS*ADDR_W-1:0]    bram_addr,
  output logic [NUM_BANKS*STREAM_WIDTH-1:0] bram_din,
  output logic [NUM_BANKS-1:0]           rd_avail,
  output logic [NUM_BANKS-1:0]           rd_half,
  output logic [NUM_BANKS*LEN_W-1:0]     rd_len,
  input  logic [NUM_BANKS-1:0]           rd_release
`ifdef IBRAM_WR_ERR_EN
  ,
  output logic                           wr_err,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int OFF_W = ADDR_W-1;
  localparam logic [LEN_W-1:0] LAST = LEN_W'(BANK_DEPTH-1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BANK_DEPTH);

  logic [NUM_BANKS-1:0] wr_half_q, wr_half_d;
  logic [NUM_BANKS-1:0] rd_half_q, rd_half_d;
  logic [LEN_W-1:0]     wr_ptr_q [NUM_BANKS];
  logic [LEN_W-1:0]     wr_ptr_d [NUM_BANKS];
  logic [1:0]           busy_q [NUM_BANKS];
  logic [1:0]           busy_d [NUM_BANKS];
  logic [LEN_W-1:0]     len_q [NUM_BANKS][2];
  logic [LEN_W-1:0]     len_d [NUM_BANKS][2];

  logic                 in_range;
  logic                 attempt;
  logic                 accept;
  logic [NUM_BANKS-1:0] acc;

  assign in_range = (32'(wr_bank) < NUM_BANKS);
  assign rd_half  = rd_half_q;

  always_comb begin
    full     = '0;
    rd_avail = '0;
    rd_len   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      full[b]     = busy_q[b][wr_half_q[b]];
      rd_avail[b] = busy_q[b][rd_half_q[b]];
      rd_len[b*LEN_W +: LEN_W] = len_q[b][rd_half_q[b]];
    end
  end

  // Out-of-range banks are treated as full so nothing is strobed.
  always_comb begin
    attempt = wr_en & wr_we;
    accept  = attempt & in_range & ~full[wr_bank];
    acc     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      acc[b] = accept & (wr_bank == BANK_W'(b));
    end
  end

  // Release frees rd_half while a seal claims wr_half; they never collide.
  always_comb begin
    wr_half_d = wr_half_q;
    rd_half_d = rd_half_q;
    wr_ptr_d  = wr_ptr_q;
    busy_d    = busy_q;
    len_d     = len_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_release[b] && rd_avail[b]) begin
        busy_d[b][rd_half_q[b]] = 1'b0;
        rd_half_d[b] = ~rd_half_q[b];
      end
      if (acc[b] && wr_ptr_q[b] == LAST) begin
        busy_d[b][wr_half_q[b]] = 1'b1;
        len_d[b][wr_half_q[b]]  = FULL_LEN;
        wr_half_d[b] = ~wr_half_q[b];
        wr_ptr_d[b]  = '0;
      end else if (wr_done && (acc[b] || wr_ptr_q[b] != '0)) begin
        busy_d[b][wr_half_q[b]] = 1'b1;
        len_d[b][wr_half_q[b]]  = wr_ptr_q[b] + LEN_W'(acc[b]);
        wr_half_d[b] = ~wr_half_q[b];
        wr_ptr_d[b]  = '0;
      end else if (acc[b]) begin
        wr_ptr_d[b] = wr_ptr_q[b] + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_half_q <= '0;
      rd_half_q <= '0;
      bram_ena  <= '0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        wr_ptr_q[b]  <= '0;
        busy_q[b]    <= '0;
        len_q[b][0]  <= '0;
        len_q[b][1]  <= '0;
      end
    end else begin
      wr_half_q <= wr_half_d;
      rd_half_q <= rd_half_d;
      wr_ptr_q  <= wr_ptr_d;
      busy_q    <= busy_d;
      len_q     <= len_d;
      bram_ena  <= acc;
      bram_we   <= acc;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (acc[b]) begin
          bram_addr[b*ADDR_W +: ADDR_W] <=
            {wr_half_q[b], wr_ptr_q[b][OFF_W-1:0]};
          bram_din[b*STREAM_WIDTH +: STREAM_WIDTH] <= wr_data;
        end
      end
    end
  end

`ifdef IBRAM_WR_ERR_EN
  logic drop;
  assign drop = attempt & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err   <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      wr_err <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
